// File: rtl/alu_pkg.sv
// Shared types for the nibble ALU slice and the loop controller that iterates it.
package alu_pkg;

  localparam int unsigned NIBBLE_W = 4;

  typedef enum logic [2:0] {
    ADD   = 3'd0,
    SUB   = 3'd1,
    AND   = 3'd2,
    OR    = 3'd3,
    XOR   = 3'd4,
    LSHFT = 3'd5,
    RSHFT = 3'd6
  } AluCmd;

  typedef struct packed {
    AluCmd cmd;
    logic  carry_in;
    logic  b_inv;
    logic  carry_disable;
  } AluCtrl;

  typedef struct packed {
    AluCtrl              ctrl;
    logic [NIBBLE_W-1:0] d1;
    logic [NIBBLE_W-1:0] d2;
  } AluArgs;

  typedef struct packed {
    logic [NIBBLE_W-1:0] res;
    logic                carry_out;
  } AluRet;

  function automatic logic is_zero(input logic [NIBBLE_W-1:0] v);
    return (v == '0);
  endfunction

endpackage

// File: rtl/alu_if.sv
// Bundle of ALU operands, combinational result and registered status outputs.
interface alu_if;
  import alu_pkg::*;

  AluArgs              args;
  AluRet               ret;
  logic                en;
  logic [NIBBLE_W-1:0] res_q;
  logic                carry_q;
  logic                zero_q;

  modport master (
    output args, en,
    input  ret, res_q, carry_q, zero_q
  );

  modport slave (
    input  args, en,
    output ret, res_q, carry_q, zero_q
  );

endinterface

// File: rtl/alu_status_reg.sv
// Registered copy of the ALU result and flags for status/debug observation.
module alu_status_reg
  import alu_pkg::*;
(
  input  logic                clk,
  input  logic                rst,
  input  logic                en,
  input  AluRet               ret,
  output logic [NIBBLE_W-1:0] res_q,
  output logic                carry_q,
  output logic                zero_q
);

  always_ff @(posedge clk) begin
    if (rst) begin
      res_q   <= '0;
      carry_q <= 1'b0;
      zero_q  <= 1'b1;
    end else if (en) begin
      res_q   <= ret.res;
      carry_q <= ret.carry_out;
      zero_q  <= is_zero(ret.res);
    end
  end

endmodule

// File: rtl/alu.sv
// Nibble ALU slice: combinational result/carry plus registered status copies.
module alu
  import alu_pkg::*;
(
  input logic  clk,
  input logic  rst,
  alu_if.slave bus
);

  logic [NIBBLE_W-1:0] b;
  logic                cin;
  logic [NIBBLE_W:0]   sum;
  AluRet               ret;

  always_comb begin
    b   = bus.args.ctrl.b_inv ? ~bus.args.d2 : bus.args.d2;
    cin = bus.args.ctrl.carry_disable ? 1'b0 : bus.args.ctrl.carry_in;
    sum = '0;
    ret = '0;
    case (bus.args.ctrl.cmd)
      ADD: begin
        sum           = {1'b0, bus.args.d1} + {1'b0, b} + {{NIBBLE_W{1'b0}}, cin};
        ret.res       = sum[NIBBLE_W-1:0];
        ret.carry_out = sum[NIBBLE_W];
      end
      SUB: begin
        sum           = {1'b0, bus.args.d1} + {1'b0, ~b} + {{NIBBLE_W{1'b0}}, cin};
        ret.res       = sum[NIBBLE_W-1:0];
        ret.carry_out = sum[NIBBLE_W];
      end
      AND: ret.res = bus.args.d1 & b;
      OR:  ret.res = bus.args.d1 | b;
      XOR: ret.res = bus.args.d1 ^ b;
      // Shifts never look at d1, so an undriven d1 cannot disturb them.
      LSHFT: begin
        ret.res       = {b[NIBBLE_W-2:0], cin};
        ret.carry_out = b[NIBBLE_W-1];
      end
      RSHFT: begin
        ret.res       = {cin, b[NIBBLE_W-1:1]};
        ret.carry_out = b[0];
      end
      default: ret = '0;
    endcase
    if (bus.args.ctrl.carry_disable)
      ret.carry_out = 1'b0;
  end

  assign bus.ret = ret;

  alu_status_reg u_status (
    .clk     (clk),
    .rst     (rst),
    .en      (bus.en),
    .ret     (ret),
    .res_q   (bus.res_q),
    .carry_q (bus.carry_q),
    .zero_q  (bus.zero_q)
  );

endmodule

// File: tb/tb_alu.sv
// Directed and randomized checks of the nibble ALU against an arithmetic reference model.
module tb_alu;
  import alu_pkg::*;

  logic clk = 1'b0;
  logic rst = 1'b1;

  alu_if bus ();

  alu dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  int unsigned vectors     = 0;
  int unsigned miscompares = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic apply(input AluCmd cmd, input logic cin, input logic binv, input logic cd,
                       input logic [3:0] d1, input logic [3:0] d2);
    AluArgs a;
    a.ctrl.cmd           = cmd;
    a.ctrl.carry_in      = cin;
    a.ctrl.b_inv         = binv;
    a.ctrl.carry_disable = cd;
    a.d1                 = d1;
    a.d2                 = d2;
    bus.args             = a;
  endtask

  // Reference: integer arithmetic on operand values; returns {carry_out, res}.
  function automatic logic [4:0] model(input int cmd, input logic cin_raw, input logic binv,
                                       input logic cd, input logic [3:0] d1, input logic [3:0] d2);
    int a, b, c, v, res, co;
    a   = int'(d1);
    b   = binv ? 15 - int'(d2) : int'(d2);
    c   = (cd || !cin_raw) ? 0 : 1;
    res = 0;
    co  = 0;
    case (cmd)
      0: begin v = a + b + c; res = v % 16; co = (v >= 16) ? 1 : 0; end
      1: begin v = a - b - (1 - c); res = (v + 32) % 16; co = (v >= 0) ? 1 : 0; end
      2: res = a & b;
      3: res = a | b;
      4: res = a ^ b;
      5: begin v = b * 2 + c; res = v % 16; co = v / 16; end
      6: begin v = c * 16 + b; res = v / 2; co = v % 2; end
      default: begin res = 0; co = 0; end
    endcase
    if (cd) co = 0;
    return {co[0], res[3:0]};
  endfunction

  logic [3:0] exp_res_q;
  logic       exp_carry_q;
  logic       exp_zero_q;

  initial begin
    logic [31:0] word;
    logic [31:0] shifted;
    logic        c;
    logic [4:0]  m;
    int          cmd;
    logic        cin, binv, cd, en_r, rst_r;
    logic [3:0]  d1, d2;

    bus.en = 1'b0;
    apply(ADD, 1'b0, 1'b0, 1'b0, 4'h0, 4'h0);

    @(posedge clk); #1;
    chk("reset_res_q", 32'(bus.res_q), 32'h0);
    chk("reset_carry_q", 32'(bus.carry_q), 32'h0);
    chk("reset_zero_q", 32'(bus.zero_q), 32'h1);
    @(negedge clk);
    rst = 1'b0;

    apply(ADD, 1'b0, 1'b0, 1'b0, 4'h4, 4'h4); #1;
    chk("add_4_4", {27'h0, bus.ret.carry_out, bus.ret.res}, {27'h0, 1'b0, 4'h8});
    apply(ADD, 1'b0, 1'b0, 1'b0, 4'hF, 4'h1); #1;
    chk("add_f_1", {27'h0, bus.ret.carry_out, bus.ret.res}, {27'h0, 1'b1, 4'h0});
    apply(ADD, 1'b1, 1'b1, 1'b0, 4'hF, 4'h0); #1;
    chk("add_binv_f", {27'h0, bus.ret.carry_out, bus.ret.res}, {27'h0, 1'b1, 4'hF});
    apply(ADD, 1'b1, 1'b1, 1'b0, 4'h0, 4'h0); #1;
    chk("add_binv_0", {27'h0, bus.ret.carry_out, bus.ret.res}, {27'h0, 1'b1, 4'h0});
    apply(SUB, 1'b1, 1'b0, 1'b0, 4'h5, 4'h3); #1;
    chk("sub_5_3", {27'h0, bus.ret.carry_out, bus.ret.res}, {27'h0, 1'b1, 4'h2});
    apply(SUB, 1'b1, 1'b0, 1'b0, 4'h3, 4'h5); #1;
    chk("sub_3_5", {27'h0, bus.ret.carry_out, bus.ret.res}, {27'h0, 1'b0, 4'hE});
    apply(RSHFT, 1'b0, 1'b0, 1'b0, 4'h0, 4'h6); #1;
    chk("rshft_6", {27'h0, bus.ret.carry_out, bus.ret.res}, {27'h0, 1'b0, 4'h3});
    apply(RSHFT, 1'b1, 1'b0, 1'b0, 4'h0, 4'h1); #1;
    chk("rshft_1_cin", {27'h0, bus.ret.carry_out, bus.ret.res}, {27'h0, 1'b1, 4'h8});
    apply(LSHFT, 1'b1, 1'b0, 1'b0, 4'h0, 4'h8); #1;
    chk("lshft_8_cin", {27'h0, bus.ret.carry_out, bus.ret.res}, {27'h0, 1'b1, 4'h1});
    apply(ADD, 1'b1, 1'b0, 1'b1, 4'hF, 4'h1); #1;
    chk("add_carry_disable", {27'h0, bus.ret.carry_out, bus.ret.res}, {27'h0, 1'b0, 4'h0});
    apply(AluCmd'(3'd7), 1'b1, 1'b0, 1'b0, 4'hF, 4'hF); #1;
    chk("undefined_cmd", {27'h0, bus.ret.carry_out, bus.ret.res}, 32'h0);

    word    = 32'h0600_0000;
    shifted = '0;
    c       = 1'b0;
    for (int i = 7; i >= 0; i--) begin
      apply(RSHFT, c, 1'b0, 1'b0, 4'h0, word[i*4 +: 4]); #1;
      shifted[i*4 +: 4] = bus.ret.res;
      c                 = bus.ret.carry_out;
    end
    chk("rshft_serial_word", shifted, 32'h0300_0000);

    for (int n = 0; n < 300; n++) begin
      cmd  = int'($urandom_range(0, 7));
      cin  = 1'($urandom);
      binv = 1'($urandom);
      cd   = ($urandom_range(0, 3) == 0);
      d1   = 4'($urandom);
      d2   = 4'($urandom);
      if ((cmd == 5 || cmd == 6) && $urandom_range(0, 1) == 1)
        d1 = 4'bxxxx;
      apply(AluCmd'(cmd[2:0]), cin, binv, cd, d1, d2); #1;
      m = model(cmd, cin, binv, cd, d1, d2);
      chk($sformatf("rand_comb_cmd%0d", cmd), {27'h0, bus.ret.carry_out, bus.ret.res}, {27'h0, m});
    end

    @(negedge clk);
    apply(ADD, 1'b0, 1'b0, 1'b0, 4'h7, 4'h1);
    bus.en = 1'b1;
    @(posedge clk); #1;
    chk("reg_add_res_q", 32'(bus.res_q), 32'h8);
    chk("reg_add_zero_q", 32'(bus.zero_q), 32'h0);
    chk("reg_add_carry_q", 32'(bus.carry_q), 32'h0);

    @(negedge clk);
    bus.en = 1'b0;
    apply(ADD, 1'b0, 1'b0, 1'b0, 4'hF, 4'h1);
    @(posedge clk); #1;
    chk("reg_hold_res_q", 32'(bus.res_q), 32'h8);
    chk("reg_hold_carry_q", 32'(bus.carry_q), 32'h0);

    @(negedge clk);
    bus.en = 1'b1;
    rst    = 1'b1;
    apply(ADD, 1'b0, 1'b0, 1'b0, 4'h3, 4'h4);
    @(posedge clk); #1;
    chk("reg_rst_wins_res_q", 32'(bus.res_q), 32'h0);
    chk("reg_rst_wins_zero_q", 32'(bus.zero_q), 32'h1);

    exp_res_q   = 4'h0;
    exp_carry_q = 1'b0;
    exp_zero_q  = 1'b1;
    for (int n = 0; n < 200; n++) begin
      @(negedge clk);
      cmd   = int'($urandom_range(0, 7));
      cin   = 1'($urandom);
      binv  = 1'($urandom);
      cd    = ($urandom_range(0, 3) == 0);
      d1    = 4'($urandom);
      d2    = 4'($urandom);
      en_r  = 1'($urandom);
      rst_r = ($urandom_range(0, 15) == 0);
      apply(AluCmd'(cmd[2:0]), cin, binv, cd, d1, d2);
      bus.en = en_r;
      rst    = rst_r;
      m = model(cmd, cin, binv, cd, d1, d2);
      if (rst_r) begin
        exp_res_q   = 4'h0;
        exp_carry_q = 1'b0;
        exp_zero_q  = 1'b1;
      end else if (en_r) begin
        exp_res_q   = m[3:0];
        exp_carry_q = m[4];
        exp_zero_q  = (m[3:0] == 4'h0);
      end
      @(posedge clk); #1;
      chk("rand_reg_status", {26'h0, bus.zero_q, bus.carry_q, bus.res_q},
          {26'h0, exp_zero_q, exp_carry_q, exp_res_q});
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
